multicycle_datapath: RTL and testbench

Parametrised multi-cycle successor to the single-cycle 16-bit datapath. It executes the same 16-bit instruction format over a DATA_W-bit data path through an internal FSM (fetch, decode, execute, memory, write-back) instead of one cycle per instruction. Instruction and data memories are external and reached through req/ack handshakes, so wait states are tolerated. Control decode stays in the external control unit, which is fed by `opcode`.

---
 rtl/multicycle_datapath.sv | 202 ++++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// Multi-cycle 16-bit-ISA datapath: FETCH/DECODE/EXEC/MEM/WB over req/ack memories.
// Optional DATAPATH_PERF_CNT_EN adds free-running cycle and retired-instruction counters.
module multicycle_datapath #(
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              jump,
    input  logic              beq,
    input  logic              bne,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              alu_src,
    input  logic              reg_dst,
    input  logic              mem_to_reg,
    input  logic              reg_write,
    input  logic [1:0]        alu_op,
    output logic [3:0]        opcode,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              instr_done
`ifdef DATAPATH_PERF_CNT_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       retired_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    typedef struct packed {
        logic       jump;
        logic       beq;
        logic       bne;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam logic [DATA_W-1:0] PC_INC = DATA_W'(2);

    state_t            state, state_nx;
    ctrl_t             ctrl;
    logic [DATA_W-1:0] pc, a_q, b_q, alu_out_q, mdr;
    logic [15:0]       ir;
    logic [DATA_W-1:0] regs [8];

    logic [2:0]        rs, rt, rd, wr_idx;
    logic [DATA_W-1:0] imm_ext, alu_b, alu_y, wb_data, br_pc, jmp_pc;
    logic              zero, br_taken;

    assign rs      = ir[11:9];
    assign rt      = ir[8:6];
    assign rd      = ir[5:3];
    assign imm_ext = {{(DATA_W-6){ir[5]}}, ir[5:0]};
    assign alu_b   = ctrl.alu_src ? imm_ext : b_q;
    assign zero    = (alu_y == '0);
    assign br_taken = (ctrl.beq && zero) || (ctrl.bne && !zero);
    // pc already points past the branch when EXEC runs
    assign br_pc   = pc + {imm_ext[DATA_W-2:0], 1'b0};
    assign jmp_pc  = {pc[DATA_W-1:13], ir[11:0], 1'b0};
    assign wr_idx  = ctrl.reg_dst ? rd : rt;
    assign wb_data = ctrl.mem_to_reg ? mdr : alu_out_q;

    always_comb begin
        alu_y = a_q + alu_b;
        unique case (ctrl.alu_op)
            2'b01: alu_y = a_q - alu_b;
            2'b10: begin
                unique case (ir[14:12])
                    3'b000: alu_y = a_q + alu_b;
                    3'b001: alu_y = a_q - alu_b;
                    3'b010: alu_y = ~a_q;
                    3'b011: alu_y = a_q << alu_b[3:0];
                    3'b100: alu_y = a_q >> alu_b[3:0];
                    3'b101: alu_y = a_q & alu_b;
                    3'b110: alu_y = a_q | alu_b;
                    3'b111: alu_y = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
                    default: alu_y = a_q + alu_b;
                endcase
            end
            default: alu_y = a_q + alu_b;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   state_nx = S_FETCH;
            S_FETCH:  if (imem_ack) state_nx = S_DECODE;
            S_DECODE: state_nx = S_EXEC;
            S_EXEC: begin
                if (ctrl.jump || ctrl.beq || ctrl.bne)      state_nx = S_FETCH;
                else if (ctrl.mem_read || ctrl.mem_write)   state_nx = S_MEM;
                else if (ctrl.reg_write)                    state_nx = S_WB;
                else                                        state_nx = S_FETCH;
            end
            S_MEM:    if (dmem_ack) state_nx = ctrl.mem_write ? S_FETCH : S_WB;
            S_WB:     state_nx = S_FETCH;
            default:  state_nx = S_IDLE;
        endcase
    end

    // outputs: requests depend on registered state only
    always_comb begin
        imem_req   = (state == S_FETCH);
        dmem_req   = (state == S_MEM);
        dmem_we    = (state == S_MEM) && ctrl.mem_write;
        instr_done = (state_nx == S_FETCH) &&
                     ((state == S_EXEC) || (state == S_MEM) || (state == S_WB));
    end

    assign opcode     = ir[15:12];
    assign imem_addr  = pc;
    assign dmem_addr  = alu_out_q;
    assign dmem_wdata = b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            ir        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr       <= '0;
            ctrl      <= '0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir <= imem_rdata;
                        pc <= pc + PC_INC;
                    end
                end
                S_DECODE: begin
                    a_q  <= regs[rs];
                    b_q  <= regs[rt];
                    ctrl <= {jump, beq, bne, mem_read, mem_write, alu_src,
                             reg_dst, mem_to_reg, reg_write, alu_op};
                end
                S_EXEC: begin
                    alu_out_q <= alu_y;
                    if (ctrl.jump)    pc <= jmp_pc;
                    else if (br_taken) pc <= br_pc;
                end
                S_MEM: begin
                    if (dmem_ack && !ctrl.mem_write) mdr <= dmem_rdata;
                end
                default: ;
            endcase
        end
    end

    // register file; reset clears all eight entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (state == S_WB && ctrl.reg_write) begin
            regs[wr_idx] <= wb_data;
        end
    end

`ifdef DATAPATH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (instr_done) retired_cnt <= retired_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: acts as control unit and both memories, drives a
// vector table of instructions and checks fetch addresses, latency and memory traffic.
`timescale 1ns/1ps
module tb_multicycle_datapath;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write;
    logic [1:0]    alu_op;
    logic [3:0]    opcode;
    logic          imem_req, imem_ack;
    logic [DW-1:0] imem_addr;
    logic [15:0]   imem_rdata;
    logic          dmem_req, dmem_we, dmem_ack;
    logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic          instr_done;
`ifdef DATAPATH_PERF_CNT_EN
    logic [31:0]   cycle_cnt, retired_cnt;
`endif

    always #5 clk = ~clk;

    multicycle_datapath #(.DATA_W(DW), .RESET_PC(16'h0040)) dut (
        .clk(clk), .rst_n(rst_n),
        .jump(jump), .beq(beq), .bne(bne), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src(alu_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_op(alu_op), .opcode(opcode),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .instr_done(instr_done)
`ifdef DATAPATH_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
`endif
    );

    // control unit: 0-7 R-type (func = opcode[2:0]), 8 addi, 9 lw, A sw, B beq, C bne,
    // D jump, E nop, F add-immediate through alu_op 11
    always_comb begin
        {jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write} = 9'b0;
        alu_op = 2'b00;
        if (!opcode[3]) begin
            alu_op = 2'b10; reg_dst = 1'b1; reg_write = 1'b1;
        end else begin
            case (opcode[2:0])
                3'h0: begin alu_src = 1'b1; reg_write = 1'b1; end
                3'h1: begin mem_read = 1'b1; alu_src = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; end
                3'h2: begin mem_write = 1'b1; alu_src = 1'b1; end
                3'h3: begin beq = 1'b1; alu_op = 2'b01; end
                3'h4: begin bne = 1'b1; alu_op = 2'b01; end
                3'h5: jump = 1'b1;
                3'h7: begin alu_op = 2'b11; alu_src = 1'b1; reg_write = 1'b1; end
                default: ;
            endcase
        end
    end

    typedef struct {
        logic [15:0] pc, ins;
        int          iw, dw, lat;
        bit          mem, we;
        logic [15:0] addr, wd, rd;
    } vec_t;
    typedef struct packed { logic we; logic [15:0] addr, wd; } mem_t;

    vec_t tbl[$];
    mem_t sb[$];
    int   n_vec = 0, n_bad = 0, n_done = 0;
    bit   pend_idrop = 0, pend_ddrop = 0, pend_done = 0;

    function automatic logic [15:0] ri(input logic [3:0] op, input logic [2:0] rs, rt, input logic [5:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [15:0] rr(input logic [3:0] op, input logic [2:0] rs, rt, rd);
        return {op, rs, rt, rd, 3'b000};
    endfunction
    function automatic vec_t mk(input logic [15:0] pc, ins, input int iw, dw, lat,
                                input bit mem, we, input logic [15:0] addr, wd, rd);
        vec_t v;
        v.pc = pc; v.ins = ins; v.iw = iw; v.dw = dw; v.lat = lat;
        v.mem = mem; v.we = we; v.addr = addr; v.wd = wd; v.rd = rd;
        return v;
    endfunction
    function automatic vec_t alu4(input logic [15:0] pc, ins);
        return mk(pc, ins, 0, 0, 4, 0, 0, 16'h0, 16'h0, 16'h0);
    endfunction
    function automatic vec_t br3(input logic [15:0] pc, ins);
        return mk(pc, ins, 0, 0, 3, 0, 0, 16'h0, 16'h0, 16'h0);
    endfunction
    function automatic vec_t st(input logic [15:0] pc, ins, input int dw, input logic [15:0] addr, wd);
        return mk(pc, ins, 0, dw, 4 + dw, 1, 1, addr, wd, 16'h0);
    endfunction
    function automatic vec_t ld(input logic [15:0] pc, ins, input int dw, input logic [15:0] addr, wd, rd);
        return mk(pc, ins, 0, dw, 5 + dw, 1, 0, addr, wd, rd);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // advance to the next falling edge, release one-cycle acks, run deferred checks
    task automatic tick();
        @(negedge clk);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        if (pend_idrop) begin chk("imem_req_after_ack", imem_req, 0); pend_idrop = 0; end
        if (pend_ddrop) begin chk("dmem_req_after_ack", dmem_req, 0); pend_ddrop = 0; end
        if (pend_done)  begin chk("instr_done_pulse", instr_done, 0); pend_done = 0; end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   lat, reqc, w;
        bit   got;
        mem_t m;
        tick();
        w = 0;
        while (!imem_req && w < 8) begin tick(); w++; end
        chk($sformatf("fetch[%0d]", idx), {imem_req, imem_addr}, {1'b1, v.pc});
        lat = 1;
        for (int k = 0; k < v.iw; k++) begin
            tick(); lat++;
            chk($sformatf("fetch_hold[%0d]", idx), {imem_req, imem_addr}, {1'b1, v.pc});
        end
        imem_rdata = v.ins; imem_ack = 1'b1; pend_idrop = 1;
        if (v.mem) sb.push_back('{v.we, v.addr, v.wd});
        reqc = 0; got = 0;
        while (!got && lat < 40) begin
            tick(); lat++;
            if (dmem_req) begin
                if (reqc == 0) begin
                    if (sb.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL dmem_access[%0d]: got request at %0h, expected none", idx, dmem_addr);
                    end else begin
                        m = sb.pop_front();
                        chk($sformatf("dmem_access[%0d]", idx), {dmem_we, dmem_addr, dmem_wdata}, m);
                    end
                end
                reqc++;
                if (reqc == v.dw + 1) begin dmem_rdata = v.rd; dmem_ack = 1'b1; pend_ddrop = 1; end
            end
            #1;
            if (instr_done) got = 1;
        end
        if (!got) begin
            n_vec++; n_bad++;
            $display("FAIL retire_timeout[%0d]: no instr_done after %0d cycles, expected at %0d", idx, lat, v.lat);
        end else n_done++;
        pend_done = got;
        chk($sformatf("latency[%0d]", idx), lat, v.lat);
        chk($sformatf("dmem_req_cycles[%0d]", idx), reqc, v.mem ? v.dw + 1 : 0);
    endtask

    initial begin
        imem_ack = 0; dmem_ack = 0; imem_rdata = '0; dmem_rdata = '0;

        tbl.push_back(alu4(16'h0040, ri(4'h8, 0, 1, 6'd5)));                    // r1 = 5
        tbl.push_back(mk(16'h0042, ri(4'h8, 0, 2, 6'd7), 2, 0, 6, 0, 0, 0, 0, 0)); // r2 = 7, 2 fetch waits
        tbl.push_back(alu4(16'h0044, rr(4'h0, 1, 2, 3)));                       // r3 = 12
        tbl.push_back(st(16'h0046, ri(4'hA, 0, 3, 6'h10), 2, 16'h0010, 16'd12));
        tbl.push_back(ld(16'h0048, ri(4'h9, 0, 4, 6'h10), 2, 16'h0010, 16'h0, 16'd12));
        tbl.push_back(st(16'h004A, ri(4'hA, 0, 4, 6'h12), 0, 16'h0012, 16'd12));
        tbl.push_back(alu4(16'h004C, rr(4'h1, 1, 2, 5)));                       // r5 = -2
        tbl.push_back(st(16'h004E, ri(4'hA, 0, 5, 6'h00), 0, 16'h0000, 16'hFFFE));
        tbl.push_back(br3(16'h0050, ri(4'hB, 1, 1, 6'h3E)));                    // beq taken -> 0x4E
        tbl.push_back(br3(16'h004E, 16'hE000));                                 // nop
        tbl.push_back(br3(16'h0050, ri(4'hC, 1, 1, 6'h3E)));                    // bne not taken
        tbl.push_back(br3(16'h0052, ri(4'hC, 1, 2, 6'd4)));                     // bne taken -> 0x5C
        tbl.push_back(br3(16'h005C, ri(4'hB, 1, 2, 6'd4)));                     // beq not taken
        tbl.push_back(alu4(16'h005E, rr(4'h2, 1, 0, 6)));                       // ~r1
        tbl.push_back(st(16'h0060, ri(4'hA, 0, 6, 6'd2), 0, 16'h0002, 16'hFFFA));
        tbl.push_back(alu4(16'h0062, rr(4'h3, 1, 3, 6)));                       // 5 << 12
        tbl.push_back(st(16'h0064, ri(4'hA, 0, 6, 6'd4), 0, 16'h0004, 16'h5000));
        tbl.push_back(alu4(16'h0066, rr(4'h4, 5, 1, 6)));                       // 0xFFFE >> 5
        tbl.push_back(st(16'h0068, ri(4'hA, 0, 6, 6'd6), 0, 16'h0006, 16'h07FF));
        tbl.push_back(alu4(16'h006A, rr(4'h5, 3, 2, 6)));                       // 12 & 7
        tbl.push_back(st(16'h006C, ri(4'hA, 0, 6, 6'd8), 0, 16'h0008, 16'h0004));
        tbl.push_back(alu4(16'h006E, rr(4'h6, 3, 2, 6)));                       // 12 | 7
        tbl.push_back(st(16'h0070, ri(4'hA, 0, 6, 6'd10), 0, 16'h000A, 16'h000F));
        tbl.push_back(alu4(16'h0072, rr(4'h7, 5, 1, 6)));                       // -2 < 5
        tbl.push_back(st(16'h0074, ri(4'hA, 0, 6, 6'd12), 0, 16'h000C, 16'h0001));
        tbl.push_back(alu4(16'h0076, rr(4'h7, 1, 5, 6)));                       // 5 < -2
        tbl.push_back(st(16'h0078, ri(4'hA, 0, 6, 6'd14), 0, 16'h000E, 16'h0000));
        tbl.push_back(alu4(16'h007A, ri(4'hF, 5, 6, 6'h3F)));                   // alu_op 11: -2 + -1
        tbl.push_back(st(16'h007C, ri(4'hA, 3, 6, 6'h3E), 0, 16'h000A, 16'hFFFD));
        tbl.push_back(ld(16'h007E, ri(4'h9, 1, 7, 6'h1F), 0, 16'h0024, 16'h0, 16'hA5A5));
        tbl.push_back(st(16'h0080, ri(4'hA, 2, 7, 6'h00), 0, 16'h0007, 16'hA5A5));
        tbl.push_back(br3(16'h0082, 16'hDFFF));                                 // jump -> 0x1FFE
        tbl.push_back(br3(16'h1FFE, 16'hE000));
        tbl.push_back(br3(16'h2000, 16'hD100));                                 // jump -> 0x2200
        tbl.push_back(br3(16'h2200, 16'hE000));

        repeat (2) @(negedge clk);
        chk("rst_req", {imem_req, dmem_req, dmem_we, instr_done}, 4'b0);
        chk("rst_opcode", opcode, 4'h0);
        chk("rst_pc", imem_addr, 16'h0040);
        chk("rst_dmem_bus", {dmem_addr, dmem_wdata}, 32'h0);
        rst_n = 1'b1;
        #1 chk("idle_cycle_req", imem_req, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(i, tbl[i]);
            if (i == 2) chk("retired_after_3", n_done, 3);
        end

        // reset while a load waits on dmem_ack
        tick();
        chk("abort_fetch", {imem_req, imem_addr}, {1'b1, 16'h2202});
        imem_rdata = ri(4'h9, 0, 7, 6'h10); imem_ack = 1'b1; pend_idrop = 1;
        tick(); tick(); tick();
        chk("abort_mem_req", {dmem_req, dmem_we, dmem_addr}, {1'b1, 1'b0, 16'h0010});
        dmem_rdata = 16'hBEEF;
        tick();
        chk("abort_mem_hold", dmem_req, 1);
        #2 rst_n = 1'b0;
        #1 chk("abort_req_drop", {imem_req, dmem_req, dmem_we}, 3'b0);
        tick(); tick();
        rst_n = 1'b1;
        #1 chk("abort_idle", imem_req, 0);
        run_vec(100, st(16'h0040, ri(4'hA, 0, 7, 6'h10), 0, 16'h0010, 16'h0000));
        chk("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
